// File: rtl/tele_rx_param.sv
// tele_rx_param: framed serial telemetry receiver with sync-pattern lock.
// The line is synchronised, sampled by a realigning bit divider and shifted
// into a frame-wide window. In HUNT the window is checked after every
// sample; once a valid frame is seen the receiver locks to the frame
// boundary and only checks at each frame wrap. Lock is dropped after
// LOCK_MISS consecutive bad frames.
// Optional feature macro: TELE_RX_ERRCNT_EN adds the o_err_cnt bad-frame
// counter, which saturates at 16'hFFFF.
module tele_rx_param #(
  parameter int                D_META    = 5,
  parameter int                BIT_DIV   = 4,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1010,
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 4,
  parameter int                LOCK_MISS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx,
  output logic              o_rx_flag,
  output logic [ADDR_W-1:0] o_rx_addr,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_locked
`ifdef TELE_RX_ERRCNT_EN
  ,
  output logic [15:0]       o_err_cnt
`endif
);

  localparam int FRAME_W = SYNC_W + ADDR_W + DATA_W + 1;
  localparam int DIV_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BCNT_W  = $clog2(FRAME_W);
  localparam int MISS_W  = $clog2(LOCK_MISS + 1);

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_W - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOCK_MISS - 1);

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  logic [D_META-1:0]  r_sync;
  logic               r_rxs_d;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic               r_eval;
  state_t             r_state;
  logic [BCNT_W-1:0]  r_bit_cnt;
  logic [MISS_W-1:0]  r_miss_cnt;
  logic               r_flag;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_locked;

  logic               w_rxs;
  logic               w_edge;
  logic               w_strobe;
  logic               w_sync_ok;
  logic               w_par_ok;
  logic               w_valid;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  state_t             w_state_next;
  logic [BCNT_W-1:0]  w_bit_cnt_next;
  logic [MISS_W-1:0]  w_miss_cnt_next;
  logic               w_eval_next;
  logic               w_flag_next;
  logic               w_load;

  assign w_rxs  = r_sync[D_META-1];
  assign w_edge = w_rxs ^ r_rxs_d;

  // Input synchroniser chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_rxs_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[D_META-2:0], i_rx};
      r_rxs_d <= w_rxs;
    end
  end

  generate
    if (BIT_DIV == 1) begin : g_div1
      // One clock per bit: sample every cycle, no realignment needed.
      always_ff @(posedge clk) begin
        r_div_cnt <= '0;
      end
      assign w_strobe = 1'b1;
    end else begin : g_divn
      // Bit divider; a line edge restarts the bit period.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_div_cnt <= '0;
        end else if (w_edge) begin
          r_div_cnt <= '0;
        end else if (r_div_cnt == DIV_W'(BIT_DIV - 1)) begin
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
      // An edge in the sampling cycle suppresses that sample.
      assign w_strobe = (r_div_cnt == DIV_W'(BIT_DIV / 2)) && !w_edge;
    end
  endgenerate

  // Frame window: one bit shifted in per sample strobe, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_strobe) begin
      r_shift <= {r_shift[FRAME_W-2:0], w_rxs};
    end
  end

  assign w_sync_ok = (r_shift[FRAME_W-1 -: SYNC_W] == SYNC_PAT);
  assign w_par_ok  = ~(^r_shift);
  assign w_valid   = w_sync_ok && w_par_ok;
  assign w_addr    = r_shift[DATA_W+1 +: ADDR_W];
  assign w_data    = r_shift[1 +: DATA_W];

  // Lock FSM next-state logic: bit counting, evaluation and miss tracking.
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_miss_cnt_next = r_miss_cnt;
    w_eval_next     = 1'b0;
    w_flag_next     = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      S_HUNT: begin
        w_eval_next = w_strobe;
        if (r_eval && w_valid) begin
          w_flag_next     = 1'b1;
          w_load          = 1'b1;
          w_state_next    = S_LOCKED;
          w_miss_cnt_next = '0;
          // A sample landing in the lock cycle is already bit 0 of the next frame.
          w_bit_cnt_next  = w_strobe ? BCNT_W'(1) : '0;
          w_eval_next     = 1'b0;
        end
      end
      S_LOCKED: begin
        if (w_strobe) begin
          if (r_bit_cnt == BCNT_LAST) begin
            w_bit_cnt_next = '0;
            w_eval_next    = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
        if (r_eval) begin
          if (w_valid) begin
            w_flag_next     = 1'b1;
            w_load          = 1'b1;
            w_miss_cnt_next = '0;
          end else if (r_miss_cnt == MISS_LAST) begin
            w_state_next    = S_HUNT;
            w_bit_cnt_next  = '0;
            w_miss_cnt_next = '0;
            w_eval_next     = w_strobe;
          end else begin
            w_miss_cnt_next = r_miss_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_HUNT;
      end
    endcase
  end

  // Lock FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_HUNT;
      r_bit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_eval     <= 1'b0;
      r_flag     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_miss_cnt <= w_miss_cnt_next;
      r_eval     <= w_eval_next;
      r_flag     <= w_flag_next;
      r_locked   <= (w_state_next == S_LOCKED);
      if (w_load) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign o_rx_flag = r_flag;
  assign o_rx_addr = r_addr;
  assign o_rx_data = r_data;
  assign o_locked  = r_locked;

`ifdef TELE_RX_ERRCNT_EN
  logic        w_bad_locked;
  logic [15:0] r_err_cnt;

  assign w_bad_locked = (r_state == S_LOCKED) && r_eval && !w_valid;

  // Saturating count of bad frames seen while locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_bad_locked && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_tele_rx_param.sv
// Directed bench for tele_rx_param at default parameters.
module tb_tele_rx_param;

  localparam int BIT_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx;
  logic        o_rx_flag;
  logic [6:0]  o_rx_addr;
  logic [3:0]  o_rx_data;
  logic        o_locked;
`ifdef TELE_RX_ERRCNT_EN
  logic [15:0] o_err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int flag_cnt = 0;
  int dbl_cnt = 0;
  logic prev_flag = 1'b0;
  int flag_times[$];

  tele_rx_param dut (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (i_rx),
    .o_rx_flag (o_rx_flag),
    .o_rx_addr (o_rx_addr),
    .o_rx_data (o_rx_data),
    .o_locked  (o_locked)
`ifdef TELE_RX_ERRCNT_EN
    ,
    .o_err_cnt (o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Flag monitor: pulse count, arrival times and over-long pulses.
  always @(negedge clk) begin
    if (o_rx_flag) begin
      flag_cnt <= flag_cnt + 1;
      flag_times.push_back(cyc);
    end
    if (o_rx_flag && prev_flag) dbl_cnt <= dbl_cnt + 1;
    prev_flag <= o_rx_flag;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int len);
    i_rx = b;
    repeat (len) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] f);
    for (int i = 15; i >= 0; i--) send_bit(f[i], BIT_DIV);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Reset with checks that all outputs are zero while rst is held.
  task automatic do_reset(input string tag);
    i_rx = 1'b0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_rst_flag"}, 32'(o_rx_flag), 32'd0);
    chk({tag, "_rst_addr"}, 32'(o_rx_addr), 32'd0);
    chk({tag, "_rst_data"}, 32'(o_rx_data), 32'd0);
    chk({tag, "_rst_lock"}, 32'(o_locked), 32'd0);
`ifdef TELE_RX_ERRCNT_EN
    chk({tag, "_rst_err"}, 32'(o_err_cnt), 32'd0);
`endif
    rst = 1'b0;
    idle(12);
  endtask

  // Frame just sent: flag exactly 6 negedges later, one cycle wide.
  task automatic expect_frame(input string tag, input logic [6:0] a, input logic [3:0] d);
    int early;
    early = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_rx_flag) early++;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    @(negedge clk);
    chk({tag, "_flag"}, 32'(o_rx_flag), 32'd1);
    chk({tag, "_addr"}, 32'(o_rx_addr), 32'(a));
    chk({tag, "_data"}, 32'(o_rx_data), 32'(d));
    chk({tag, "_lock"}, 32'(o_locked), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(o_rx_flag), 32'd0);
  endtask

  initial begin
    int base;
    int cnt;
    int bad;
    int lens[16];
    logic [15:0] fr;

    rst  = 1'b1;
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_flag", 32'(o_rx_flag), 32'd0);
    chk("por_addr", 32'(o_rx_addr), 32'd0);
    chk("por_data", 32'(o_rx_data), 32'd0);
    chk("por_lock", 32'(o_locked), 32'd0);
    rst = 1'b0;
    idle(12);

    // Good frame in HUNT locks and reports 55/A.
    send_frame(16'hAAB4);
    expect_frame("good", 7'h55, 4'hA);
    do_reset("t1");

    // Parity error in HUNT: nothing happens.
    cnt = 0;
    send_frame(16'hAAB5);
    repeat (8) begin
      @(negedge clk);
      if (o_rx_flag) cnt++;
    end
    chk("par_flag", 32'(cnt), 32'd0);
    chk("par_addr", 32'(o_rx_addr), 32'd0);
    chk("par_data", 32'(o_rx_data), 32'd0);
    chk("par_lock", 32'(o_locked), 32'd0);
`ifdef TELE_RX_ERRCNT_EN
    chk("par_err", 32'(o_err_cnt), 32'd0);
`endif
    do_reset("t2");

    // Lock, then two bad-sync frames drop lock.
    base = flag_cnt;
    send_frame(16'hAAB4);
    send_frame(16'h5AB4);
    send_frame(16'h5AB4);
    repeat (5) @(negedge clk);
    chk("drop_lock_hold", 32'(o_locked), 32'd1);
    @(negedge clk);
    chk("drop_lock_fall", 32'(o_locked), 32'd0);
    chk("drop_flags", 32'(flag_cnt - base), 32'd1);
    chk("drop_addr", 32'(o_rx_addr), 32'h55);
`ifdef TELE_RX_ERRCNT_EN
    chk("drop_err", 32'(o_err_cnt), 32'd2);
`endif
    do_reset("t3");

    // Lock, bad, good 01/3, bad: lock survives.
    base = flag_cnt;
    send_frame(16'hAAB4);
    send_frame(16'h5AB4);
    send_frame(16'hA027);
    send_frame(16'h5AB4);
    repeat (6) @(negedge clk);
    chk("mix_flags", 32'(flag_cnt - base), 32'd2);
    chk("mix_addr", 32'(o_rx_addr), 32'h01);
    chk("mix_data", 32'(o_rx_data), 32'h3);
    chk("mix_lock", 32'(o_locked), 32'd1);
`ifdef TELE_RX_ERRCNT_EN
    chk("mix_err", 32'(o_err_cnt), 32'd2);
`endif
    do_reset("t4");

    // Reset after 8 bits discards the partial frame.
    base = flag_cnt;
    fr = 16'hAAB4;
    for (int i = 15; i >= 8; i--) send_bit(fr[i], BIT_DIV);
    i_rx = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(48);
    chk("partial_flags", 32'(flag_cnt - base), 32'd0);
    chk("partial_lock", 32'(o_locked), 32'd0);
    send_frame(16'hAAB4);
    expect_frame("after_rst", 7'h55, 4'hA);
    do_reset("t5");

    // Jittered bit periods, six back-to-back frames.
    base = flag_times.size();
    cnt  = flag_cnt;
    fr   = 16'hAAB4;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) lens[i] = BIT_DIV;
      if (f % 2 == 1) begin
        lens[10] = BIT_DIV + 1;
        lens[11] = BIT_DIV - 1;
      end
      if (f % 3 != 0) begin
        lens[14] = BIT_DIV + 1;
        lens[15] = BIT_DIV - 1;
      end
      if (f != 0) lens[2 * f - 1] = BIT_DIV + 1;
      for (int i = 0; i < 16; i++) send_bit(fr[15 - i], lens[i]);
    end
    repeat (8) @(negedge clk);
    chk("jit_flags", 32'(flag_cnt - cnt), 32'd6);
    chk("jit_lock", 32'(o_locked), 32'd1);
    chk("jit_addr", 32'(o_rx_addr), 32'h55);
    bad = 0;
    for (int k = base + 1; k < flag_times.size(); k++) begin
      if ((flag_times[k] - flag_times[k - 1] < 62) || (flag_times[k] - flag_times[k - 1] > 66)) bad++;
    end
    chk("jit_interval", 32'(bad), 32'd0);
    chk("pulse_width", 32'(dbl_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
